// File: rtl/alp_dq_unit.sv
// D/Q register unit for the ALP datapath slice: microcode decode, D/Q registers, Q shift-right step sequencer.
// Build macro ALP_DQ_STEP_EN includes the step sequencer; without it Q is driven by the decode alone.
//
// state    | meaning
// ST_IDLE  | Q/D follow the microcode decode; waiting for step_start_h
// ST_RUN   | Q shifts right once per cycle, rem counts the steps left
module alp_dq_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk_h,
  input  logic             rst_h,
  input  logic             dmove_h,
  input  logic             dreg_inh_l,
  input  logic [1:0]       dq_h,
  input  logic [3:0]       mux_h,
  input  logic [WIDTH-1:0] amux_h,
  input  logic [WIDTH-1:0] wmux_h,
  input  logic             qshl_in_h,
  input  logic             qshr_in_h,
  input  logic             step_start_h,
  input  logic [CNT_W-1:0] step_cnt_h,
  output logic [WIDTH-1:0] d_h,
  output logic [WIDTH-1:0] q_h,
  output logic             qlsb_h,
  output logic             qmsb_h,
  output logic             step_busy_h,
  output logic             step_done_h
);

  logic qreg_en, src_a, src_w, src_shr, src_shl, dreg_en;
  logic run;
  logic [WIDTH-1:0] q_next;

  assign qreg_en = ~(mux_h[2] & ~dq_h[0]) & ~(~mux_h[0] & ~dq_h[0]);
  assign src_a   = dmove_h;
  assign src_w   = (~dmove_h & mux_h[2]) | (~mux_h[2] & ~mux_h[0]);
  assign src_shr = (~mux_h[0] & ~dq_h[0]) | (~dmove_h & ~mux_h[2] & mux_h[0] & dq_h[0]);
  assign src_shl = ~dq_h[0];
  assign dreg_en = (dq_h[1] | (mux_h == 4'b1001)) & dreg_inh_l;

`ifdef ALP_DQ_STEP_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] rem;

  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      state <= ST_IDLE;
      rem   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (step_start_h && (step_cnt_h != '0)) begin
            state <= ST_RUN;
            rem   <= step_cnt_h;
          end
        end
        ST_RUN: begin
          rem <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          rem   <= '0;
        end
      endcase
    end
  end

  assign run         = (state == ST_RUN);
  assign step_busy_h = run;
  assign step_done_h = run && (rem == CNT_W'(1));
`else
  logic unused_step;
  assign unused_step = step_start_h ^ (^step_cnt_h);
  assign run         = 1'b0;
  assign step_busy_h = 1'b0;
  assign step_done_h = 1'b0;
`endif

  // The sequencer shift wins over the decode and ignores qreg_en.
  always_comb begin
    q_next = q_h;
    if (run) begin
      q_next = {qshr_in_h, q_h[WIDTH-1:1]};
    end else if (qreg_en) begin
      if (src_a)        q_next = amux_h;
      else if (src_w)   q_next = wmux_h;
      else if (src_shr) q_next = {qshr_in_h, q_h[WIDTH-1:1]};
      else if (src_shl) q_next = {q_h[WIDTH-2:0], qshl_in_h};
    end
  end

  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      q_h <= '0;
      d_h <= '0;
    end else begin
      q_h <= q_next;
      if (dreg_en) d_h <= wmux_h;
    end
  end

  assign qlsb_h = q_h[0];
  assign qmsb_h = q_h[WIDTH-1];

endmodule

// File: tb/tb_alp_dq_unit.sv
// Self-checking bench for alp_dq_unit: directed vector table, step-sequencer sequences, random run vs reference model.
module tb_alp_dq_unit;
  localparam int W  = 8;
  localparam int CW = 5;
`ifdef ALP_DQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic          clk_h = 1'b0;
  logic          rst_h, dmove_h, dreg_inh_l, qshl_in_h, qshr_in_h, step_start_h;
  logic [1:0]    dq_h;
  logic [3:0]    mux_h;
  logic [W-1:0]  amux_h, wmux_h, d_h, q_h;
  logic [CW-1:0] step_cnt_h;
  logic          qlsb_h, qmsb_h, step_busy_h, step_done_h;

  always #5 clk_h = ~clk_h;

  alp_dq_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_h(clk_h), .rst_h(rst_h), .dmove_h(dmove_h), .dreg_inh_l(dreg_inh_l),
    .dq_h(dq_h), .mux_h(mux_h), .amux_h(amux_h), .wmux_h(wmux_h),
    .qshl_in_h(qshl_in_h), .qshr_in_h(qshr_in_h), .step_start_h(step_start_h),
    .step_cnt_h(step_cnt_h), .d_h(d_h), .q_h(q_h), .qlsb_h(qlsb_h), .qmsb_h(qmsb_h),
    .step_busy_h(step_busy_h), .step_done_h(step_done_h)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents plus number of sequencer shifts still owed.
  logic [W-1:0] mq = '0;
  logic [W-1:0] md = '0;
  int           mrem = 0;

  typedef struct {
    logic rst, dm, inh;
    logic [1:0] dq;
    logic [3:0] m;
    logic [7:0] a, w;
    logic shl, shr;
    logic [7:0] exp_d, exp_q;
  } vec_t;
  vec_t tv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic dq0, m0, m2, en;
    dq0 = dq_h[0]; m0 = mux_h[0]; m2 = mux_h[2];
    if (rst_h) begin
      mq = '0; md = '0; mrem = 0;
    end else begin
      if ((dq_h[1] || mux_h == 4'd9) && dreg_inh_l) md = wmux_h;
      if (mrem > 0) begin
        mq = {qshr_in_h, mq[W-1:1]};
        mrem--;
      end else begin
        en = !(m2 && !dq0) && !(!m0 && !dq0);
        if (en) begin
          if (dmove_h) mq = amux_h;
          else if ((!dmove_h && m2) || (!m2 && !m0)) mq = wmux_h;
          else if ((!m0 && !dq0) || (!dmove_h && !m2 && m0 && dq0)) mq = {qshr_in_h, mq[W-1:1]};
          else if (!dq0) mq = {mq[W-2:0], qshl_in_h};
        end
        if (STEP_EN && step_start_h && step_cnt_h != 0) mrem = int'(step_cnt_h);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_h);
    #1;
    check("d", d_h, md);
    check("q", q_h, mq);
    check("qlsb", qlsb_h, mq[0]);
    check("qmsb", qmsb_h, mq[W-1]);
    check("busy", step_busy_h, mrem > 0);
    check("done", step_done_h, mrem == 1);
  endtask

  task automatic set_dec(input logic dm, input logic inh, input logic [1:0] dq, input logic [3:0] m);
    dmove_h = dm; dreg_inh_l = inh; dq_h = dq; mux_h = m;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt;
    logic done_seen;

    rst_h = 1'b0; step_start_h = 1'b0; step_cnt_h = '0;
    qshl_in_h = 1'b0; qshr_in_h = 1'b0; amux_h = '0; wmux_h = '0;
    set_dec(1'b0, 1'b1, 2'b00, 4'b0100);

    //            rst dm  inh dq     m        a      w      shl shr  exp_d  exp_q
    tv[0] = '{1'b1, 1'b1, 1'b0, 2'b11, 4'hF,    8'hFF, 8'hEE, 1'b1, 1'b1, 8'h00, 8'h00};
    tv[1] = '{1'b0, 1'b1, 1'b1, 2'b01, 4'b0101, 8'hA5, 8'h11, 1'b0, 1'b0, 8'h00, 8'hA5};
    tv[2] = '{1'b0, 1'b0, 1'b0, 2'b11, 4'b0100, 8'h00, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h3C};
    tv[3] = '{1'b0, 1'b0, 1'b1, 2'b00, 4'b1001, 8'h00, 8'h77, 1'b1, 1'b0, 8'h77, 8'h79};
    tv[4] = '{1'b0, 1'b0, 1'b1, 2'b00, 4'b0100, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h77, 8'h79};
    tv[5] = '{1'b0, 1'b0, 1'b1, 2'b01, 4'b0001, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h77, 8'h3C};
    tv[6] = '{1'b0, 1'b0, 1'b1, 2'b01, 4'b0000, 8'h00, 8'hC3, 1'b0, 1'b0, 8'h77, 8'hC3};
    tv[7] = '{1'b0, 1'b0, 1'b1, 2'b10, 4'b0101, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h5A, 8'hC3};

    for (int i = 0; i < 8; i++) begin
      rst_h = tv[i].rst;
      set_dec(tv[i].dm, tv[i].inh, tv[i].dq, tv[i].m);
      amux_h = tv[i].a; wmux_h = tv[i].w;
      qshl_in_h = tv[i].shl; qshr_in_h = tv[i].shr;
      tick();
      check($sformatf("tv%0d_d", i), d_h, tv[i].exp_d);
      check($sformatf("tv%0d_q", i), q_h, tv[i].exp_q);
      check($sformatf("tv%0d_busy", i), step_busy_h, 1'b0);
    end

    // Count-3 step run from Q = 80 with a second start attempted mid-run.
    set_dec(1'b1, 1'b0, 2'b01, 4'b0101); amux_h = 8'h80;
    tick();
    set_dec(1'b0, 1'b0, 2'b00, 4'b0100); qshr_in_h = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step_start_h = (c == 0) || (c == 2);
      step_cnt_h   = (c == 0) ? 5'd3 : 5'd7;
      tick();
      busy_cnt += int'(step_busy_h);
      done_cnt += int'(step_done_h);
    end
    step_start_h = 1'b0;
    check("step3_busy_cycles", busy_cnt, STEP_EN ? 3 : 0);
    check("step3_done_pulses", done_cnt, STEP_EN ? 1 : 0);
    check("step3_q_final", q_h, STEP_EN ? 8'h10 : 8'h80);

    // Start with count 0 is ignored.
    step_start_h = 1'b1; step_cnt_h = 5'd0;
    tick();
    step_start_h = 1'b0;
    check("cnt0_busy", step_busy_h, 1'b0);
    tick();

    // Count-5 run aborted by reset on the second busy cycle.
    set_dec(1'b1, 1'b0, 2'b01, 4'b0101); amux_h = 8'hF0;
    tick();
    set_dec(1'b0, 1'b0, 2'b00, 4'b0100);
    step_start_h = 1'b1; step_cnt_h = 5'd5;
    tick();
    step_start_h = 1'b0;
    done_seen = step_done_h;
    tick();
    done_seen |= step_done_h;
    rst_h = 1'b1;
    tick();
    rst_h = 1'b0;
    check("rst_run_busy", step_busy_h, 1'b0);
    check("rst_run_q", q_h, 8'h00);
    for (int c = 0; c < 6; c++) begin
      tick();
      done_seen |= step_done_h;
    end
    check("rst_run_no_done", done_seen, 1'b0);

    // Randomized run against the reference model.
    for (int c = 0; c < 600; c++) begin
      rst_h        = ($urandom_range(0, 40) == 0);
      dmove_h      = ($urandom_range(0, 3) == 0);
      dreg_inh_l   = ($urandom_range(0, 3) != 0);
      dq_h         = 2'($urandom);
      mux_h        = 4'($urandom);
      amux_h       = 8'($urandom);
      wmux_h       = 8'($urandom);
      qshl_in_h    = 1'($urandom);
      qshr_in_h    = 1'($urandom);
      step_start_h = ($urandom_range(0, 5) == 0);
      step_cnt_h   = 5'($urandom_range(0, 9));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
